// File: rtl/cache_arbiter.sv
// Arbitrates the single pmem line port between the icache and dcache.
// Alternating priority on ties; responses are steered only to the granted cache.
module cache_arbiter #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {StIdle, StServeI, StServeD} state_e;

  state_e state;
  logic   last_d;
  logic   d_req;

  assign d_req = d_read | d_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= StIdle;
      last_d <= 1'b1;
    end else begin
      unique case (state)
        StIdle: begin
          // On a tie, grant whichever cache was not served last.
          if (i_read && d_req) state <= last_d ? StServeI : StServeD;
          else if (i_read)     state <= StServeI;
          else if (d_req)      state <= StServeD;
        end
        StServeI: begin
          if (pmem_resp) begin
            state  <= StIdle;
            last_d <= 1'b0;
          end
        end
        StServeD: begin
          if (pmem_resp) begin
            state  <= StIdle;
            last_d <= 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Strobes depend only on state and requests, never on pmem_resp.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_resp       = 1'b0;
    i_rdata      = '0;
    d_resp       = 1'b0;
    d_rdata      = '0;
    unique case (state)
      StServeI: begin
        pmem_read    = i_read;
        pmem_address = i_address;
        i_resp       = pmem_resp;
        i_rdata      = pmem_resp ? pmem_rdata : '0;
      end
      StServeD: begin
        pmem_write   = d_write;
        pmem_read    = d_read & ~d_write;
        pmem_address = d_address;
        pmem_wdata   = d_wdata;
        d_resp       = pmem_resp;
        d_rdata      = pmem_resp ? pmem_rdata : '0;
      end
      default: ;
    endcase
  end

endmodule
